// File: rtl/systolic_pkg.sv
// Shared types, default dimensions and tile-length helper for the systolic array controller.
package systolic_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned K_MAX_DEF = 7;
  localparam int unsigned ACC_W     = 18;
  localparam int unsigned A_W       = 8;
  localparam int unsigned B_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // RUN length: last operand enters lane N-1 at k_len-1+(N-1) and crosses N-1 more hops.
  function automatic int unsigned tile_cycles(input int unsigned k_len, input int unsigned n);
    return k_len + 2 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// Combinational skewed lane schedule: lane i is live for t in [i, k_len+i) and reads K index t-i.
module skew_lane_gen #(
  parameter int unsigned N   = 4,
  parameter int unsigned K_W = 3,
  parameter int unsigned T_W = 4
) (
  input  logic [T_W-1:0]   t,
  input  logic [K_W-1:0]   k_len,
  output logic [N-1:0]     lane_en,
  output logic [N*K_W-1:0] lane_k
);

  always_comb begin
    lane_en = '0;
    lane_k  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((32'(t) >= i) && (32'(t) < 32'(k_len) + i)) begin
        lane_en[i]          = 1'b1;
        lane_k[i*K_W +: K_W] = K_W'(32'(t) - i);
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for an N x N output-stationary systolic array: clear, skewed feed, drain, done.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned K_MAX = K_MAX_DEF,
  parameter int unsigned K_W   = $clog2(K_MAX + 1),
  parameter int unsigned T_W   = $clog2(K_MAX + 2 * N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [K_W-1:0]   k_len,
  input  logic             abort,
  output logic             pe_clr,
  output logic [N-1:0]     lane_en,
  output logic [N*K_W-1:0] lane_k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  ctrl_state_t      state, state_nxt;
  logic [T_W-1:0]   t, t_nxt, last_t;
  logic [K_W-1:0]   k_lat, k_nxt;
  logic             clr_nxt, done_nxt, err_nxt, run_nxt;
  logic [N-1:0]     en_c;
  logic [N*K_W-1:0] lk_c;

  assign last_t  = T_W'(tile_cycles(32'(k_lat), N) - 32'd1);
  assign run_nxt = (state_nxt == RUN);

  // Schedule is evaluated for the upcoming cycle so the registered lanes line up with t.
  skew_lane_gen #(
    .N   (N),
    .K_W (K_W),
    .T_W (T_W)
  ) u_skew (
    .t       (t_nxt),
    .k_len   (k_nxt),
    .lane_en (en_c),
    .lane_k  (lk_c)
  );

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    k_nxt     = k_lat;
    clr_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((k_len != '0) && (32'(k_len) <= K_MAX)) begin
            state_nxt = CLEAR;
            k_nxt     = k_len;
            t_nxt     = '0;
            clr_nxt   = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      CLEAR: begin
        t_nxt = '0;
        if (abort) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Abort scrubs the accumulators on the way back to IDLE.
        if (abort) begin
          state_nxt = IDLE;
          t_nxt     = '0;
          clr_nxt   = 1'b1;
        end else if (t == last_t) begin
          state_nxt = DONE;
          t_nxt     = '0;
          done_nxt  = 1'b1;
        end else begin
          t_nxt = t + T_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      t       <= '0;
      k_lat   <= '0;
      pe_clr  <= 1'b0;
      lane_en <= '0;
      lane_k  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      t       <= t_nxt;
      k_lat   <= k_nxt;
      pe_clr  <= clr_nxt;
      lane_en <= run_nxt ? en_c : '0;
      lane_k  <= run_nxt ? lk_c : '0;
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

endmodule
